// File: rtl/buzzer_arbiter_n.sv
// Quiz-show buzzer arbiter: first eligible rising buzz wins, host judges, countdown with alarm.
// Latency: every output is a register; an input sampled on edge k is visible just after edge k.
// Backpressure: none; inputs are levels sampled every cycle, and illegal-state inputs are ignored.
//
// Ports:
//   i_clk           single clock, rising edge
//   i_rst           synchronous reset, active-low
//   i_start         open a round (IDLE only)
//   i_buzz          debounced player buttons, bit i = player i
//   i_judge_ok      answer correct (ANSWER only)
//   i_judge_bad     answer wrong   (ANSWER only), wins over i_judge_ok
//   i_clear_scores  zero all scores and foul flags, any state
//   o_winner        one-hot current responder, 0 when none
//   o_winner_id     index of responder, 0 when none
//   o_time_left     remaining countdown ticks
//   o_scores        packed scores, player i at [i*SCORE_W +: SCORE_W]
//   o_foul          players locked out of the next round for buzzing early
//   o_state         0 IDLE, 1 ARMED, 2 ANSWER
//   o_alarm         timeout indicator, sticky until next start or reset
module buzzer_arbiter_n #(
  parameter int N_PLAYERS   = 4,
  parameter int SCORE_W     = 8,
  parameter int TICK_DIV    = 100_000_000,
  parameter int ANSWER_SECS = 20,
  localparam int ID_W       = (N_PLAYERS > 2) ? $clog2(N_PLAYERS) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic [N_PLAYERS-1:0]         i_buzz,
  input  logic                         i_judge_ok,
  input  logic                         i_judge_bad,
  input  logic                         i_clear_scores,
  output logic [N_PLAYERS-1:0]         o_winner,
  output logic [ID_W-1:0]              o_winner_id,
  output logic [7:0]                   o_time_left,
  output logic [N_PLAYERS*SCORE_W-1:0] o_scores,
  output logic [N_PLAYERS-1:0]         o_foul,
  output logic [1:0]                   o_state,
  output logic                         o_alarm
);

  localparam int                 DIV_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [7:0]         RELOAD    = 8'(ANSWER_SECS);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_ANSWER = 2'd2
  } state_t;

  state_t                            r_state, w_state_nxt;
  logic [N_PLAYERS-1:0]              r_buzz_q;
  logic [N_PLAYERS-1:0]              r_winner, w_winner_nxt;
  logic [ID_W-1:0]                   r_winner_id, w_winner_id_nxt;
  logic [7:0]                        r_time_left, w_time_left_nxt;
  logic [N_PLAYERS-1:0]              r_foul, w_foul_nxt;
  logic                              r_alarm, w_alarm_nxt;
  logic [DIV_W-1:0]                  r_div, w_div_nxt;
  logic [N_PLAYERS-1:0][SCORE_W-1:0] r_score, w_score_nxt;

  logic [N_PLAYERS-1:0] w_edge, w_elig, w_pick;
  logic [ID_W-1:0]      w_pick_id;
  logic                 w_tick, w_inc, w_dec;

  assign w_edge = i_buzz & ~r_buzz_q;
  assign w_elig = w_edge & ~r_foul;
  // Two's-complement trick isolates the lowest set bit: lowest index wins ties.
  assign w_pick = w_elig & (~w_elig + N_PLAYERS'(1));
  assign w_tick = (r_state != S_IDLE) && (r_div == DIV_LAST);

  always_comb begin
    w_pick_id = '0;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (w_elig[i]) w_pick_id = ID_W'(i);
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_winner_nxt    = r_winner;
    w_winner_id_nxt = r_winner_id;
    w_time_left_nxt = r_time_left;
    w_foul_nxt      = r_foul;
    w_alarm_nxt     = r_alarm;
    w_div_nxt       = '0;
    w_score_nxt     = r_score;
    w_inc           = 1'b0;
    w_dec           = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_foul_nxt = r_foul | w_edge;
        if (i_start) begin
          w_state_nxt     = S_ARMED;
          w_time_left_nxt = RELOAD;
          w_winner_nxt    = '0;
          w_winner_id_nxt = '0;
          w_alarm_nxt     = 1'b0;
        end
      end
      S_ARMED: begin
        w_div_nxt = w_tick ? '0 : r_div + DIV_W'(1);
        // A winner on the same edge as a tick takes precedence and reloads the count.
        if (w_elig != '0) begin
          w_state_nxt     = S_ANSWER;
          w_winner_nxt    = w_pick;
          w_winner_id_nxt = w_pick_id;
          w_time_left_nxt = RELOAD;
          w_div_nxt       = '0;
          w_foul_nxt      = '0;
        end else if (w_tick) begin
          if (r_time_left == 8'd1) begin
            w_state_nxt     = S_IDLE;
            w_time_left_nxt = 8'd0;
            w_alarm_nxt     = 1'b1;
            w_foul_nxt      = '0;
          end else begin
            w_time_left_nxt = r_time_left - 8'd1;
          end
        end
      end
      S_ANSWER: begin
        w_div_nxt = w_tick ? '0 : r_div + DIV_W'(1);
        // A judge on the timeout edge wins, so no alarm in that case.
        if (i_judge_bad) begin
          w_dec       = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (i_judge_ok) begin
          w_inc       = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_tick) begin
          if (r_time_left == 8'd1) begin
            w_dec           = 1'b1;
            w_alarm_nxt     = 1'b1;
            w_time_left_nxt = 8'd0;
            w_state_nxt     = S_IDLE;
          end else begin
            w_time_left_nxt = r_time_left - 8'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    for (int i = 0; i < N_PLAYERS; i++) begin
      if (r_winner[i]) begin
        if (w_inc && (r_score[i] != SCORE_MAX)) begin
          w_score_nxt[i] = r_score[i] + SCORE_W'(1);
        end else if (w_dec && (r_score[i] != '0)) begin
          w_score_nxt[i] = r_score[i] - SCORE_W'(1);
        end
      end
    end

    if (i_clear_scores) begin
      w_score_nxt = '0;
      w_foul_nxt  = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= S_IDLE;
      r_winner    <= '0;
      r_winner_id <= '0;
      r_time_left <= 8'd0;
      r_foul      <= '0;
      r_alarm     <= 1'b0;
      r_div       <= '0;
      r_score     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_winner    <= w_winner_nxt;
      r_winner_id <= w_winner_id_nxt;
      r_time_left <= w_time_left_nxt;
      r_foul      <= w_foul_nxt;
      r_alarm     <= w_alarm_nxt;
      r_div       <= w_div_nxt;
      r_score     <= w_score_nxt;
    end
  end

  // The edge detector keeps tracking the buttons during reset (it reads 0 when
  // nobody is pressing), so a button held through reset is not seen as a fresh press.
  always_ff @(posedge i_clk) begin
    r_buzz_q <= i_buzz;
  end

  assign o_winner    = r_winner;
  assign o_winner_id = r_winner_id;
  assign o_time_left = r_time_left;
  assign o_scores    = r_score;
  assign o_foul      = r_foul;
  assign o_state     = r_state;
  assign o_alarm     = r_alarm;

endmodule

// File: tb/tb_buzzer_arbiter_n.sv
module tb_buzzer_arbiter_n;

  localparam int N    = 4;
  localparam int SW   = 4;
  localparam int TD   = 4;
  localparam int AS   = 3;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          judge_ok = 1'b0;
  logic          judge_bad = 1'b0;
  logic          clear_scores = 1'b0;
  logic [N-1:0]  buzz = '0;
  logic [N-1:0]  winner;
  logic [1:0]    winner_id;
  logic [7:0]    time_left;
  logic [N*SW-1:0] scores;
  logic [N-1:0]  foul;
  logic [1:0]    state;
  logic          alarm;

  int n_checks = 0;
  int n_fail   = 0;

  buzzer_arbiter_n #(
    .N_PLAYERS(N), .SCORE_W(SW), .TICK_DIV(TD), .ANSWER_SECS(AS)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_buzz(buzz),
    .i_judge_ok(judge_ok), .i_judge_bad(judge_bad), .i_clear_scores(clear_scores),
    .o_winner(winner), .o_winner_id(winner_id), .o_time_left(time_left),
    .o_scores(scores), .o_foul(foul), .o_state(state), .o_alarm(alarm)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  // Behavioural reference: game rules expressed as plain integer bookkeeping.
  int           m_state;   // 0 idle, 1 armed, 2 answer
  int           m_win = -1;
  int           m_time, m_cyc, m_alarm;
  int           m_score[N];
  logic [N-1:0] m_foul = '0;
  logic [N-1:0] m_bq   = '0;

  task automatic model_step();
    logic [N-1:0] presses, eligible;
    bit tick, plus, minus;
    plus = 0; minus = 0;
    if (!rst) begin
      m_state = 0; m_win = -1; m_time = 0; m_cyc = 0; m_alarm = 0; m_foul = '0;
      foreach (m_score[i]) m_score[i] = 0;
    end else begin
      presses  = buzz & ~m_bq;
      eligible = presses & ~m_foul;
      tick     = (m_state != 0) && (m_cyc % TD == TD - 1);
      m_cyc++;
      case (m_state)
        0: begin
          m_foul |= presses;
          if (start) begin
            m_state = 1; m_time = AS; m_win = -1; m_alarm = 0; m_cyc = 0;
          end
        end
        1: begin
          if (eligible != 0) begin
            for (int i = N - 1; i >= 0; i--) if (eligible[i]) m_win = i;
            m_state = 2; m_time = AS; m_cyc = 0; m_foul = '0;
          end else if (tick) begin
            m_time--;
            if (m_time == 0) begin m_alarm = 1; m_foul = '0; m_state = 0; end
          end
        end
        2: begin
          if (judge_bad) begin minus = 1; m_state = 0; end
          else if (judge_ok) begin plus = 1; m_state = 0; end
          else if (tick) begin
            m_time--;
            if (m_time == 0) begin minus = 1; m_alarm = 1; m_state = 0; end
          end
        end
        default: m_state = 0;
      endcase
      if (plus)  m_score[m_win] = (m_score[m_win] >= SMAX) ? SMAX : m_score[m_win] + 1;
      if (minus) m_score[m_win] = (m_score[m_win] <= 0) ? 0 : m_score[m_win] - 1;
      if (clear_scores) begin
        foreach (m_score[i]) m_score[i] = 0;
        m_foul = '0;
      end
    end
    m_bq = buzz;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic play_round(input int p, input bit ok, input bit bad);
    start = 1; cyc(); start = 0;
    buzz = '0; buzz[p] = 1'b1; cyc();
    buzz = '0; judge_ok = ok; judge_bad = bad; cyc();
    judge_ok = 0; judge_bad = 0;
  endtask

  task automatic test_reset();
    rst = 0; cyc(); cyc();
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
    n_checks++; if (winner !== 4'b0) begin n_fail++; $display("FAIL reset_winner: got %b want 0000", winner); end
    n_checks++; if (winner_id !== 2'd0) begin n_fail++; $display("FAIL reset_winner_id: got %0d want 0", winner_id); end
    n_checks++; if (time_left !== 8'd0) begin n_fail++; $display("FAIL reset_time_left: got %0d want 0", time_left); end
    n_checks++; if (scores !== 16'h0) begin n_fail++; $display("FAIL reset_scores: got %h want 0000", scores); end
    n_checks++; if (foul !== 4'b0) begin n_fail++; $display("FAIL reset_foul: got %b want 0000", foul); end
    n_checks++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL reset_alarm: got %b want 0", alarm); end
    rst = 1;
  endtask

  task automatic test_first_buzz();
    start = 1; cyc(); start = 0;
    buzz = 4'b0110; cyc();
    n_checks++; if (winner !== 4'b0010) begin n_fail++; $display("FAIL tie_winner: got %b want 0010", winner); end
    n_checks++; if (winner_id !== 2'd1) begin n_fail++; $display("FAIL tie_winner_id: got %0d want 1", winner_id); end
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL tie_state: got %0d want 2", state); end
    n_checks++; if (time_left !== 8'd3) begin n_fail++; $display("FAIL tie_time_left: got %0d want 3", time_left); end
    buzz = '0; judge_ok = 1; cyc(); judge_ok = 0;
    n_checks++; if (scores[1*SW +: SW] !== 4'd1) begin n_fail++; $display("FAIL tie_score: got %0d want 1", scores[1*SW +: SW]); end
  endtask

  task automatic test_foul();
    buzz = 4'b1000; cyc(); buzz = '0; cyc();
    n_checks++; if (foul !== 4'b1000) begin n_fail++; $display("FAIL foul_set: got %b want 1000", foul); end
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL foul_idle_state: got %0d want 0", state); end
    start = 1; cyc(); start = 0;
    buzz = 4'b1000; cyc();
    n_checks++; if ({state, winner, foul} !== {2'd1, 4'b0000, 4'b1000}) begin
      n_fail++; $display("FAIL foul_lockout: got st=%0d win=%b foul=%b want st=1 win=0000 foul=1000", state, winner, foul);
    end
    buzz = '0; cyc();
    buzz = 4'b0001; cyc();
    n_checks++; if ({state, winner, foul} !== {2'd2, 4'b0001, 4'b0000}) begin
      n_fail++; $display("FAIL foul_clear_on_win: got st=%0d win=%b foul=%b want st=2 win=0001 foul=0000", state, winner, foul);
    end
    buzz = '0; judge_bad = 1; cyc(); judge_bad = 0;
  endtask

  task automatic test_countdown();
    start = 1; cyc(); start = 0;
    for (int k = 1; k <= 12; k++) begin
      logic [10:0] want;
      cyc();
      want = {(k == 12) ? 2'd0 : 2'd1, 8'(3 - k / 4), (k == 12)};
      n_checks++;
      if ({state, time_left, alarm} !== want) begin
        n_fail++;
        $display("FAIL countdown_k%0d: got st=%0d tl=%0d al=%b want st=%0d tl=%0d al=%b",
                 k, state, time_left, alarm, want[10:9], want[8:1], want[0]);
      end
    end
  endtask

  task automatic test_saturate();
    clear_scores = 1; cyc(); clear_scores = 0;
    for (int r = 0; r < 16; r++) begin
      int want;
      play_round(2, 1'b1, 1'b0);
      want = (r + 1 > SMAX) ? SMAX : r + 1;
      n_checks++;
      if (scores[2*SW +: SW] !== SW'(want)) begin
        n_fail++; $display("FAIL saturate_round%0d: got %0d want %0d", r, scores[2*SW +: SW], want);
      end
    end
    play_round(2, 1'b1, 1'b1);
    n_checks++; if (scores[2*SW +: SW] !== 4'd14) begin n_fail++; $display("FAIL both_judges: got %0d want 14", scores[2*SW +: SW]); end
  endtask

  task automatic test_answer_timeout();
    clear_scores = 1; cyc(); clear_scores = 0;
    start = 1; cyc(); start = 0;
    buzz = 4'b0001; cyc(); buzz = '0;
    repeat (11) cyc();
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL ans_timeout_pre: got st=%0d want 2", state); end
    cyc();
    n_checks++; if ({state, alarm, scores[0 +: SW], time_left} !== {2'd0, 1'b1, 4'd0, 8'd0}) begin
      n_fail++; $display("FAIL ans_timeout: got st=%0d al=%b s0=%0d tl=%0d want st=0 al=1 s0=0 tl=0", state, alarm, scores[0 +: SW], time_left);
    end
    start = 1; cyc(); start = 0;
    n_checks++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL alarm_clear_on_start: got %b want 0", alarm); end
    buzz = 4'b0001; cyc(); buzz = '0;
    repeat (11) cyc();
    judge_ok = 1; cyc(); judge_ok = 0;
    n_checks++; if ({state, alarm, scores[0 +: SW]} !== {2'd0, 1'b0, 4'd1}) begin
      n_fail++; $display("FAIL judge_at_timeout: got st=%0d al=%b s0=%0d want st=0 al=0 s0=1", state, alarm, scores[0 +: SW]);
    end
  endtask

  task automatic test_reset_mid();
    clear_scores = 1; cyc(); clear_scores = 0;
    repeat (5) play_round(1, 1'b1, 1'b0);
    start = 1; cyc(); start = 0;
    buzz = 4'b0010; cyc();
    n_checks++; if ({state, scores[1*SW +: SW]} !== {2'd2, 4'd5}) begin
      n_fail++; $display("FAIL reset_mid_setup: got st=%0d s1=%0d want st=2 s1=5", state, scores[1*SW +: SW]);
    end
    rst = 0; cyc();
    n_checks++; if ({state, winner, winner_id, time_left, scores, foul, alarm} !== 37'd0) begin
      n_fail++; $display("FAIL reset_mid: got st=%0d win=%b id=%0d tl=%0d sc=%h foul=%b al=%b want all zero",
                         state, winner, winner_id, time_left, scores, foul, alarm);
    end
    rst = 1; cyc();
    n_checks++; if (foul !== 4'b0000) begin n_fail++; $display("FAIL held_buzz_after_reset: got foul=%b want 0000", foul); end
    start = 1; cyc(); start = 0; cyc();
    n_checks++; if ({state, winner} !== {2'd1, 4'b0000}) begin
      n_fail++; $display("FAIL held_buzz_no_win: got st=%0d win=%b want st=1 win=0000", state, winner);
    end
    buzz = '0; cyc();
  endtask

  task automatic test_random();
    for (int k = 0; k < 4000 && n_fail < 50; k++) begin
      logic [N-1:0]    w_win;
      logic [N*SW-1:0] w_sc;
      logic [36:0]     want, got;
      rst          = ($urandom_range(0, 299) != 0);
      start        = ($urandom_range(0, 7) == 0);
      judge_ok     = ($urandom_range(0, 9) == 0);
      judge_bad    = ($urandom_range(0, 11) == 0);
      clear_scores = ($urandom_range(0, 99) == 0);
      for (int b = 0; b < N; b++) if ($urandom_range(0, 5) == 0) buzz[b] = ~buzz[b];
      cyc();
      w_win = '0;
      if (m_win >= 0) w_win[m_win] = 1'b1;
      for (int i = 0; i < N; i++) w_sc[i*SW +: SW] = SW'(m_score[i]);
      want = {2'(m_state), w_win, 2'((m_win < 0) ? 0 : m_win), 8'(m_time), w_sc, m_foul, 1'(m_alarm)};
      got  = {state, winner, winner_id, time_left, scores, foul, alarm};
      n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL random_cycle%0d: got %h want %h", k, got, want);
      end
    end
    rst = 1; start = 0; judge_ok = 0; judge_bad = 0; clear_scores = 0; buzz = '0;
  endtask

  initial begin
    test_reset();
    test_first_buzz();
    test_foul();
    test_countdown();
    test_saturate();
    test_answer_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
